// File: rtl/ifid_hazard_ctrl_pkg.sv
// Shared types and constants for the IF/ID hazard and sequencing controller.
package ifid_hazard_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Encoding that a cleared IF/ID register presents to decode (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // True when the instruction in ID reads the register a load in EX is about to write.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        return mem_read && (rd != REG_ZERO) &&
               ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones, return to zero on clr.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID and PC sequencing controller: resolves redirects, load-use hazards and
// instruction-memory wait states with fixed priority, and keeps perf counters.
module ifid_hazard_ctrl
    import ifid_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic             ex_redirect,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             IFIDWrite,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             fetch_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // fcnt value loaded on a redirect: the redirect cycle itself is the first flush cycle.
    localparam logic [2:0]  FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    // fetch_timeout sets on the wait cycle that brings wcnt up to WAIT_TIMEOUT.
    localparam logic [15:0] WAIT_LAST    = 16'(WAIT_TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [2:0]  fcnt;
    logic [2:0]  fcnt_next;
    logic [15:0] wcnt;
    logic        load_use;
    logic        stall_inc;
    logic        flush_inc;
    logic        wait_inc;
    logic        wait_clr;

    assign load_use = load_use_hit(idex_mem_read, idex_rd, id_rs1, id_rs2,
                                   id_uses_rs1, id_uses_rs2);

    // Same-cycle hazard decision: outputs, next state and counter strobes, in priority order.
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        next_state = state;
        fcnt_next  = fcnt;
        pc_write   = 1'b0;
        IFIDWrite  = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        wait_inc   = 1'b0;
        wait_clr   = 1'b0;

        if (!reset) begin
            // Safe quiescent pipeline while reset is held.
            IFIDWrite  = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            next_state = RUN;
            fcnt_next  = '0;
        end else if (ex_redirect) begin
            pc_write   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
            wait_clr   = 1'b1;
            fcnt_next  = FLUSH_RELOAD;
            next_state = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (state == FLUSH) begin
            pc_write   = imem_ready;
            ifid_flush = 1'b1;
            if (fcnt <= 3'd1) begin
                fcnt_next  = '0;
                next_state = RUN;
            end else begin
                fcnt_next  = fcnt - 3'd1;
            end
        end else if ((state != STALL) && load_use) begin
            // The bubble already sits in ID/EX during STALL, so the hazard is not re-checked there.
            IFIDWrite  = 1'b1;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
            next_state = STALL;
        end else if (!imem_ready) begin
            ifid_flush = 1'b1;
            wait_inc   = 1'b1;
            next_state = WAIT;
        end else begin
            pc_write   = 1'b1;
            wait_clr   = 1'b1;
            next_state = RUN;
        end
    end

    // State, flush countdown and the sticky timeout flag.
    // NOTE: asynchronous active-low reset puts the controller into RUN as soon as reset falls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            fcnt          <= '0;
            fetch_timeout <= 1'b0;
        end else begin
            state <= next_state;
            fcnt  <= fcnt_next;
            if (wait_inc && (wcnt >= WAIT_LAST)) begin
                fetch_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (1'b0),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (1'b0),
        .inc   (flush_inc),
        .count (flush_count)
    );

    sat_counter #(.W(16)) u_wait_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (wait_clr),
        .inc   (wait_inc),
        .count (wcnt)
    );

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Directed bench: two controllers share stimulus; dut uses FLUSH_CYCLES=2 with
// 32-bit counters, dut3 uses FLUSH_CYCLES=3 with 2-bit counters to reach saturation.
module tb_ifid_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, idex_rd;
    logic        id_uses_rs1, id_uses_rs2, idex_mem_read, ex_redirect, imem_ready;

    logic        pc_write, ifid_write, ifid_flush, idex_flush, fetch_timeout;
    logic [31:0] stall_count, flush_count;
    logic        pc_write3, ifid_write3, ifid_flush3, idex_flush3, fetch_timeout3;
    logic [1:0]  stall_count3, flush_count3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ifid_hazard_ctrl #(.FLUSH_CYCLES(2), .WAIT_TIMEOUT(4), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .ex_redirect   (ex_redirect),
        .imem_ready    (imem_ready),
        .pc_write      (pc_write),
        .IFIDWrite     (ifid_write),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .fetch_timeout (fetch_timeout),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    ifid_hazard_ctrl #(.FLUSH_CYCLES(3), .WAIT_TIMEOUT(4), .CNT_W(2)) dut3 (
        .clk           (clk),
        .reset         (reset),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .ex_redirect   (ex_redirect),
        .imem_ready    (imem_ready),
        .pc_write      (pc_write3),
        .IFIDWrite     (ifid_write3),
        .ifid_flush    (ifid_flush3),
        .idex_flush    (idex_flush3),
        .fetch_timeout (fetch_timeout3),
        .stall_count   (stall_count3),
        .flush_count   (flush_count3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Packs {pc_write, IFIDWrite, ifid_flush, idex_flush} for one-line output checks.
    function automatic logic [31:0] outs(input logic p, input logic h, input logic f, input logic b);
        return {28'd0, p, h, f, b};
    endfunction

    task automatic idle_inputs();
        id_rs1        = 5'd0;
        id_rs2        = 5'd0;
        id_uses_rs1   = 1'b0;
        id_uses_rs2   = 1'b0;
        idex_mem_read = 1'b0;
        idex_rd       = 5'd0;
        ex_redirect   = 1'b0;
        imem_ready    = 1'b1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        idex_mem_read = 1'b1;
        idex_rd       = rd;
        id_rs2        = 5'd5;
        id_uses_rs2   = 1'b1;
    endtask

    // Inputs change at the falling edge; outputs settle 1 time unit later.
    task automatic begin_cycle();
        @(negedge clk);
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        #1;
        check("reset_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(0, 1, 1, 1));
        end_cycle();
        end_cycle();
        check("reset_stall_cnt", stall_count, 0);
        check("reset_flush_cnt", flush_count, 0);
        check("reset_timeout", {31'd0, fetch_timeout}, 0);

        // Normal fetch.
        begin_cycle(); reset = 1'b1; #1;
        check("normal_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(1, 0, 0, 0));
        end_cycle();

        // Load-use on rs2: hold IF/ID, bubble into ID/EX.
        begin_cycle(); set_load_use(5'd5); #1;
        check("lu_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(0, 1, 0, 1));
        end_cycle();
        check("lu_stall_cnt", stall_count, 1);
        // STALL cycle: same operands still present, but the hazard is not re-evaluated.
        begin_cycle(); #1;
        check("lu_resume_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(1, 0, 0, 0));
        end_cycle();
        check("lu_resume_cnt", stall_count, 1);

        // Load into x0 is not a hazard.
        begin_cycle(); set_load_use(5'd0); #1;
        check("x0_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(1, 0, 0, 0));
        end_cycle();
        check("x0_stall_cnt", stall_count, 1);
        // Matching rs1 that is not read is not a hazard either.
        begin_cycle(); idle_inputs(); idex_mem_read = 1'b1; idex_rd = 5'd7; id_rs1 = 5'd7; #1;
        check("rs1_unused_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(1, 0, 0, 0));
        end_cycle();

        // One-cycle redirect: dut flushes IF/ID 2 cycles, dut3 for 3.
        begin_cycle(); idle_inputs(); ex_redirect = 1'b1; #1;
        check("redir_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(1, 0, 1, 1));
        end_cycle();
        check("redir_flush_cnt", flush_count, 1);
        begin_cycle(); ex_redirect = 1'b0; #1;
        check("flush2_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(1, 0, 1, 0));
        check("flush3_c1_outs", outs(pc_write3, ifid_write3, ifid_flush3, idex_flush3), outs(1, 0, 1, 0));
        end_cycle();
        begin_cycle(); imem_ready = 1'b0; #1;
        check("flush_done_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(0, 0, 1, 0));
        check("flush3_c2_outs", outs(pc_write3, ifid_write3, ifid_flush3, idex_flush3), outs(0, 0, 1, 0));
        check("flush3_c2_ifid", {31'd0, ifid_flush3}, 1);
        end_cycle();
        // dut took a wait cycle above; a ready cycle clears it.
        begin_cycle(); imem_ready = 1'b1; #1;
        check("after_flush_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(1, 0, 0, 0));
        check("after_flush3_outs", outs(pc_write3, ifid_write3, ifid_flush3, idex_flush3), outs(1, 0, 0, 0));
        end_cycle();

        // Reset pulse in the middle of dut3's FLUSH sequence.
        begin_cycle(); ex_redirect = 1'b1; end_cycle();
        begin_cycle(); ex_redirect = 1'b0; #1;
        check("preflush3_outs", outs(pc_write3, ifid_write3, ifid_flush3, idex_flush3), outs(1, 0, 1, 0));
        #1; reset = 1'b0; #1;
        check("midreset3_outs", outs(pc_write3, ifid_write3, ifid_flush3, idex_flush3), outs(0, 1, 1, 1));
        check("midreset_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(0, 1, 1, 1));
        end_cycle();
        check("midreset_flush_cnt", flush_count, 0);
        check("midreset_stall_cnt", stall_count, 0);
        check("midreset_flush_cnt3", {30'd0, flush_count3}, 0);
        begin_cycle(); reset = 1'b1; #1;
        check("postreset3_outs", outs(pc_write3, ifid_write3, ifid_flush3, idex_flush3), outs(1, 0, 0, 0));
        end_cycle();

        // Redirect and load-use together: redirect wins, no stall counted.
        begin_cycle(); set_load_use(5'd5); ex_redirect = 1'b1; #1;
        check("redir_lu_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(1, 0, 1, 1));
        end_cycle();
        check("redir_lu_stall", stall_count, 0);
        check("redir_lu_flush", flush_count, 1);
        begin_cycle(); idle_inputs(); end_cycle();
        begin_cycle(); end_cycle();
        begin_cycle(); end_cycle();

        // Load-use with imem not ready: the hold wins, then wait cycles build up to timeout.
        begin_cycle(); set_load_use(5'd5); imem_ready = 1'b0; #1;
        check("lu_wait_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(0, 1, 0, 1));
        end_cycle();
        check("lu_wait_stall", stall_count, 1);
        for (int i = 1; i <= 4; i++) begin
            begin_cycle(); idle_inputs(); imem_ready = 1'b0; #1;
            check($sformatf("wait%0d_outs", i),
                  outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(0, 0, 1, 0));
            end_cycle();
            check($sformatf("wait%0d_timeout", i), {31'd0, fetch_timeout}, (i == 4) ? 1 : 0);
        end
        begin_cycle(); imem_ready = 1'b1; #1;
        check("ready_again_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(1, 0, 0, 0));
        end_cycle();
        check("timeout_sticky", {31'd0, fetch_timeout}, 1);

        // Back-to-back redirects: each one counts; dut3's 2-bit counter saturates at 3.
        for (int i = 0; i < 4; i++) begin
            begin_cycle(); ex_redirect = 1'b1; end_cycle();
        end
        check("redir_burst_cnt", flush_count, 5);
        check("redir_sat_cnt3", {30'd0, flush_count3}, 3);
        begin_cycle(); ex_redirect = 1'b0; #1;
        check("burst_tail_outs", outs(pc_write, ifid_write, ifid_flush, idex_flush), outs(1, 0, 1, 0));
        end_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifid_hazard_ctrl.md
Name: ifid_hazard_ctrl

Overview:
- Hazard and sequencing controller for the IF/ID pipeline register and the PC.
- Each cycle it decides whether IF/ID loads, holds or is flushed, whether the PC advances, and whether a bubble is injected into ID/EX.
- It resolves load-use hazards, taken-branch/jump redirects and instruction-memory wait states, in a fixed priority order.
- It keeps saturating performance counters and a sticky fetch-timeout flag.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles IF/ID is flushed per redirect (1..7).
- WAIT_TIMEOUT, 255, consecutive imem-not-ready cycles before fetch_timeout sets (1..65535).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- idex_mem_read  in  1  instruction in EX is a load.
- idex_rd  in  5  destination register of the instruction in EX.
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle.
- imem_ready  in  1  instruction memory returned valid data this cycle.
- pc_write  out  1  1 = PC updates (sequential or redirect target).
- IFIDWrite  out  1  IF/ID enable, codebase polarity: 0 = load, 1 = hold.
- ifid_flush  out  1  1 = IF/ID clears to zero (NOP) at the next edge.
- idex_flush  out  1  1 = ID/EX clears to a bubble at the next edge.
- fetch_timeout  out  1  sticky error flag; cleared only by reset.
- stall_count  out  CNT_W  load-use stall cycles, saturating.
- flush_count  out  CNT_W  redirect events, saturating.

Behaviour:
- State: FSM {RUN, STALL, FLUSH, WAIT}, a 3-bit flush counter fcnt, a 16-bit wait counter wcnt, and the two performance counters. All are registered.
- Outputs: pc_write, IFIDWrite, ifid_flush and idex_flush are combinational from state plus current inputs. This gives zero-latency hazard response in the same cycle.
- Reset asserted (reset=0): state=RUN, fcnt=0, wcnt=0, counters=0, fetch_timeout=0. Outputs are pc_write=0, IFIDWrite=1, ifid_flush=1, idex_flush=1. Reset mid-operation aborts any state immediately.
- Load-use hazard: load_use = idex_mem_read & (idex_rd != 0) & ((id_uses_rs1 & idex_rd==id_rs1) | (id_uses_rs2 & idex_rd==id_rs2)).
- Priority per cycle: redirect > FLUSH continuation > load_use > imem wait > normal.
- Redirect (ex_redirect=1, any state): pc_write=1, ifid_flush=1, idex_flush=1, IFIDWrite=0. flush_count is incremented.
  - If FLUSH_CYCLES>1: next state=FLUSH with fcnt=FLUSH_CYCLES-1.
  - Otherwise: next state=RUN.
  - wcnt is cleared.
- FLUSH (no new redirect): pc_write=imem_ready, ifid_flush=1, idex_flush=0. fcnt is decremented; move to RUN when fcnt reaches 1.
  - A new redirect while in FLUSH reloads fcnt and increments flush_count again.
- Load-use (RUN or WAIT only): pc_write=0, IFIDWrite=1 (hold), ifid_flush=0, idex_flush=1. stall_count is incremented; next state=STALL.
- STALL: load_use is not evaluated (ID/EX now holds the bubble). Normal rules apply; next state=RUN, or WAIT if imem_ready=0.
- Imem wait (imem_ready=0, no higher priority event): pc_write=0, ifid_flush=1, IFIDWrite=0, idex_flush=0. Next state=WAIT and wcnt is incremented (saturating).
  - When wcnt reaches WAIT_TIMEOUT, fetch_timeout sets and stays set.
- Normal (RUN/WAIT with imem_ready=1): pc_write=1, IFIDWrite=0, both flushes 0, wcnt=0, next state=RUN.
- Simultaneous events:
  - Load-use together with imem_ready=0: the load-use hold wins, and WAIT is entered next cycle if still not ready.
  - Redirect together with load_use: the redirect wins, and stall_count is not incremented.
- Invariant: ifid_flush=1 and IFIDWrite=1 are never driven together outside reset.
- Counters saturate at all-ones and never wrap.

Decomposition:
- Shared package: the FSM state enum, REG_ZERO=5'd0, and the NOP encoding used for cleared IF/ID contents.
- One natural sub-module, sat_counter (parameter W, inputs inc/clr). It is instantiated for stall_count, flush_count and wcnt.

Test Plan:
- Reset pulse mid-FLUSH with FLUSH_CYCLES=3: outputs go immediately to reset values; after release state=RUN and counters=0.
- Load-use case: idex_mem_read=1, idex_rd=5, id_rs2=5, id_uses_rs2=1.
  - Cycle 0: pc_write=0, IFIDWrite=1, idex_flush=1, stall_count=1.
  - Cycle 1: with the EX bubble, normal flow resumes.
- Same as the load-use case but idex_rd=0: no stall; pc_write=1, stall_count stays 0.
- ex_redirect=1 for one cycle with FLUSH_CYCLES=2: ifid_flush=1 for 2 cycles, idex_flush=1 for the first cycle only, flush_count=1.
- ex_redirect and load_use in the same cycle: redirect outputs only; stall_count unchanged.
- imem_ready held 0 with WAIT_TIMEOUT=4: ifid_flush=1 and pc_write=0 each cycle.
  - fetch_timeout rises after the 4th wait cycle and stays 1 after imem_ready returns to 1.
